// File: rtl/gray_counter_n.sv
// gray_counter_n: N-bit up/down Gray-code counter with sync load, optional
// saturation, registered binary mirror, terminal-count and wrap flags.
// q is its own register loaded with gray(next state), so it never glitches
// and always equals gray(bin).
module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,     // async, active low
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] b, nb, ng;
  logic             at_end, nwrap;

  // The end of the range in the current direction; tc and the wrap/saturate
  // decision both key off this.
  assign at_end = up ? (b == MAXV) : (b == '0);
  assign tc     = en & ~load & at_end;

  // Next-state select: load beats enable beats hold.
  always_comb begin
    nb    = b;
    nwrap = 1'b0;
    if (load) begin
      nb = load_val;
    end else if (en) begin
      if (at_end) begin
        if (!SATURATE) begin
          nb    = up ? '0 : MAXV;
          nwrap = 1'b1;
        end
      end else begin
        nb = up ? b + ONE : b - ONE;
      end
    end
  end

  // Gray encode of the next state, bit by bit; MSB passes straight through.
  assign ng[WIDTH-1] = nb[WIDTH-1];
  for (genvar i = 0; i < WIDTH-1; i++) begin : g_gray
    assign ng[i] = nb[i] ^ nb[i+1];
  end

  // State, Gray output and wrap pulse all update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b    <= '0;
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      b    <= nb;
      q    <= ng;
      wrap <= nwrap;
    end
  end

  assign bin = b;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed + randomised bench for gray_counter_n: three instances
// (3-bit wrap, 4-bit saturate, 8-bit wrap) on one clock and reset.
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 3-bit wrapping instance
  logic       en3, up3, ld3, tc3, wr3;
  logic [2:0] lv3, q3, b3;
  // 4-bit saturating instance
  logic       en4, up4, ld4, tc4, wr4;
  logic [3:0] lv4, q4, b4;
  // 8-bit wrapping instance
  logic       en8, up8, ld8, tc8, wr8;
  logic [7:0] lv8, q8, b8;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) d3 (
    .clk(clk), .reset(reset), .en(en3), .up(up3), .load(ld3), .load_val(lv3),
    .q(q3), .bin(b3), .tc(tc3), .wrap(wr3));
  gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) d4 (
    .clk(clk), .reset(reset), .en(en4), .up(up4), .load(ld4), .load_val(lv4),
    .q(q4), .bin(b4), .tc(tc4), .wrap(wr4));
  gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) d8 (
    .clk(clk), .reset(reset), .en(en8), .up(up8), .load(ld8), .load_val(lv8),
    .q(q8), .bin(b8), .tc(tc8), .wrap(wr8));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hand-computed tables
  logic [2:0] t1_q [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
  logic [2:0] t1_b [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       t1_w [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic       t1_t [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0}; // tc before each edge
  logic [2:0] t2_b [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
  logic [2:0] t2_q [7] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b000, 3'b100, 3'b101};
  logic       t2_w [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    int unsigned mb, mq, pq, r;
    logic mw, mt;
    reset = 1'b0;
    {en3, up3, ld3, lv3} = '0;
    {en4, up4, ld4, lv4} = '0;
    {en8, up8, ld8, lv8} = '0;
    #12;
    chk("rst_q3", 32'(q3), 0);
    chk("rst_b3", 32'(b3), 0);
    chk("rst_w3", 32'(wr3), 0);
    chk("rst_b4", 32'(b4), 0);
    chk("rst_b8", 32'(b8), 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // 1: up count with wrap
    en3 = 1; up3 = 1;
    for (int i = 0; i < 9; i++) begin
      #1 chk($sformatf("t1_tc%0d", i), 32'(tc3), 32'(t1_t[i]));
      step();
      chk($sformatf("t1_q%0d", i), 32'(q3), 32'(t1_q[i]));
      chk($sformatf("t1_b%0d", i), 32'(b3), 32'(t1_b[i]));
      chk($sformatf("t1_w%0d", i), 32'(wr3), 32'(t1_w[i]));
    end

    // 2: load 5 then count down across 0
    en3 = 0; ld3 = 1; lv3 = 3'd5;
    step();
    chk("t2_ldb", 32'(b3), 5);
    chk("t2_ldq", 32'(q3), 32'b111);
    ld3 = 0; en3 = 1; up3 = 0;
    for (int i = 0; i < 7; i++) begin
      #1 chk($sformatf("t2_tc%0d", i), 32'(tc3), (i == 5) ? 1 : 0);
      step();
      chk($sformatf("t2_b%0d", i), 32'(b3), 32'(t2_b[i]));
      chk($sformatf("t2_q%0d", i), 32'(q3), 32'(t2_q[i]));
      chk($sformatf("t2_w%0d", i), 32'(wr3), 32'(t2_w[i]));
    end

    // 4: load beats enable, then hold
    ld3 = 1; en3 = 1; up3 = 1; lv3 = 3'd3;
    #1 chk("t4_tc_ld", 32'(tc3), 0);
    step();
    chk("t4_b", 32'(b3), 3);
    chk("t4_q", 32'(q3), 32'b010);
    ld3 = 0; en3 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_hq%0d", i), 32'(q3), 32'b010);
      chk($sformatf("t4_hw%0d", i), 32'(wr3), 0);
    end

    // 5: async reset mid-count at bin=6
    en3 = 1; up3 = 1;
    repeat (3) step();
    chk("t5_b6", 32'(b3), 6);
    #2 reset = 1'b0;
    #1;
    chk("t5_rq", 32'(q3), 0);
    chk("t5_rb", 32'(b3), 0);
    chk("t5_rw", 32'(wr3), 0);
    #1 reset = 1'b1;
    step();
    chk("t5_b1", 32'(b3), 1);
    chk("t5_q1", 32'(q3), 1);
    en3 = 0;

    // 3: saturating 4-bit up, then one step down
    en4 = 1; up4 = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("t3_w%0d", i), 32'(wr4), 0);
    end
    chk("t3_b", 32'(b4), 15);
    chk("t3_q", 32'(q4), 32'b1000);
    chk("t3_tc", 32'(tc4), 1);
    up4 = 0;
    step();
    chk("t3_db", 32'(b4), 14);
    chk("t3_dq", 32'(q4), 32'b1001);
    en4 = 0;

    // 6: random 8-bit run against a behavioural model
    mb = 0; pq = 0;
    chk("t6_b0", 32'(b8), 0);
    for (int i = 0; i < 10000; i++) begin
      en8 = 1'($urandom);
      up8 = 1'($urandom);
      ld8 = ($urandom_range(0, 15) == 0);
      r   = $urandom_range(0, 3);
      lv8 = (r == 0) ? 8'hff : (r == 1) ? 8'h00 : 8'($urandom);
      #1;
      mt = en8 && !ld8 && (up8 ? (mb == 255) : (mb == 0));
      chk("t6_tc", 32'(tc8), 32'(mt));
      mw = 0;
      if (ld8) mb = 32'(lv8);
      else if (en8) begin
        if (up8) begin
          if (mb == 255) begin mb = 0; mw = 1; end else mb = mb + 1;
        end else begin
          if (mb == 0) begin mb = 255; mw = 1; end else mb = mb - 1;
        end
      end
      mq = mb ^ (mb >> 1);
      step();
      chk("t6_b", 32'(b8), mb);
      chk("t6_q", 32'(q8), mq);
      chk("t6_w", 32'(wr8), 32'(mw));
      chk("t6_qg", 32'(q8), 32'(b8 ^ (b8 >> 1)));
      if (!ld8) chk("t6_ham", ($countones(32'(q8) ^ pq) <= 1) ? 1 : 0, 1);
      pq = 32'(q8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
